scene_sequencer: RTL and testbench
==================================

Name: scene_sequencer

Overview:
Frame-synchronous scheduler that drives the rendering and audio configuration (background_state, solid_color, audio_en) into the pixel colour generator and audio source. In autoplay it steps through a programmable table of scenes, each held for a set number of video frames. In manual mode it passes through the SPI-supplied configuration. All output changes happen only at the vsync frame boundary, so a frame never tears mid-display.

Parameters:
NUM_SCENES, 8, scene table depth; power of two; index width IDX_W = log2(NUM_SCENES).
FRAME_W, 8, width of the per-scene duration field, in frames.
VSYNC_ACTIVE_LOW, 1, 1: vsync asserted when low; 0: asserted when high.

Ports:
clk  in  1  pixel clock, shared with the hvsync generator.
rst_n  in  1  synchronous, active-low reset.
vsync  in  1  vertical sync from the hvsync generator.
run  in  1  1 = autoplay enabled; 0 = pause.
manual_mode  in  1  asynchronous SPI-domain select for pass-through; synchronized internally.
spi_background_state  in  8  SPI-supplied background state; quasi-static.
spi_solid_color  in  6  SPI-supplied colour; quasi-static.
spi_audio_en  in  1  SPI-supplied audio enable; quasi-static.
cfg_we  in  1  scene-table write strobe.
cfg_addr  in  IDX_W  scene-table write index.
cfg_data  in  FRAME_W+15  {duration[FRAME_W-1:0], audio_en, solid_color[5:0], background_state[7:0]}.
background_state  out  8  to pixel colour generator.
solid_color  out  6  to pixel colour generator.
audio_en  out  1  to audio source.
scene_idx  out  IDX_W  current table index.
mode  out  2  0 = IDLE, 1 = PLAY, 2 = MANUAL.
frame_tick  out  1  one-cycle frame-boundary pulse.

Behaviour:
- Reset (rst_n = 0 at a clk edge): background_state, solid_color, audio_en, scene_idx, frame_tick and the frame counter all go to 0. mode = IDLE. Synchronizer flops clear. Every table entry becomes {duration = 1, audio 0, colour 0, bg 0}.
- vsync handling: vsync is registered, then converted to an active level per VSYNC_ACTIVE_LOW.
  - frame_tick = 1 for exactly one cycle: the cycle after the registered active level goes 0→1.
  - vsync held active for many cycles produces one tick only.
- manual_mode passes through a 2-flop synchronizer (2-cycle latency) to give man_s.
- State transitions, scene_idx updates and output updates occur only on the clk edge where frame_tick = 1. Between ticks, all outputs hold. Output change latency is 1 cycle after frame_tick.
- Table writes: when cfg_we = 1, the entry at cfg_addr is written at that edge, at any time and in any state.
  - If a write and a load of the same entry coincide, the load uses the pre-write contents.
- State machine, evaluated at frame_tick with priority MANUAL > PLAY > IDLE:
  - Any state with man_s = 1 → MANUAL.
    - Outputs load spi_*.
    - scene_idx and the frame counter freeze.
    - spi_* are sampled only at this edge.
  - IDLE with run = 1 → PLAY.
    - Load entry[scene_idx] into the outputs.
    - counter = max(duration, 1) - 1.
  - IDLE with run = 0: stay in IDLE; outputs hold their last values.
  - PLAY with run = 0 → IDLE. scene_idx, outputs and counter hold (pause).
  - PLAY with run = 1 and counter ≠ 0: counter decrements.
  - PLAY with run = 1 and counter = 0: advance to the next scene.
    - scene_idx = (scene_idx == NUM_SCENES-1) ? 0 : scene_idx + 1.
    - Load that entry; counter = max(duration, 1) - 1.
  - MANUAL with man_s = 0 → PLAY if run = 1, else IDLE.
    - On entering PLAY: reload entry[scene_idx] with a fresh counter.
    - On entering IDLE: outputs hold the manual values.
- Duration semantics:
  - duration = 0 is treated as 1.
  - A scene with duration D drives the outputs for exactly D frames.
  - Maximum is 2^FRAME_W - 1 frames.
- Resume after pause (IDLE → PLAY) restarts the current scene with its full duration.
- No arithmetic overflow is possible: the counter only decrements from ≤ 2^FRAME_W - 2, and the index wraps explicitly.

Test Plan:
1. Reset: assert rst_n = 0 for 1 cycle mid-PLAY -> next cycle all outputs 0, mode = 0, scene_idx = 0; after run = 1 and a tick, entry 0 loads as {dur 1, all 0}.
2. Autoplay/wrap: write entry0 = {dur 2, bg 0x01}, entry1 = {dur 0, bg 0x02}, others default; run = 1 -> bg = 0x01 from tick 1 (held through tick 2), bg = 0x02 at tick 3, scene_idx = 2 at tick 4, scene_idx = 7 at tick 9, scene_idx = 0 and bg = 0x01 at tick 10.
3. Manual override: set spi bg = 0xA5, solid = 0x2A, audio = 1 and raise manual_mode mid-PLAY at scene 3 -> at the first tick ≥ 3 cycles later: mode = 2, outputs A5/2A/1, scene_idx stays 3; drop manual_mode -> at the next tick after sync: mode = 1, entry3 reloaded with full duration.
4. Pause/resume: run = 0 in scene 1 of a dur-5 entry after 2 frames -> next tick mode = 0, outputs unchanged for ≥ 3 ticks; run = 1 -> scene 1 runs a full 5 frames, then scene 2.
5. Tear-free/edge detection: change spi_* and write the current entry mid-frame; hold vsync active for 2000 cycles -> exactly one frame_tick per vsync assertion, and no output change except 1 cycle after a tick.
6. Polarity: VSYNC_ACTIVE_LOW = 0 with an active-high vsync pulse -> frame_tick one cycle after the registered rising edge, none on the falling edge.

Source files
------------

// File: rtl/scene_sequencer_if.sv
// scene_sequencer_if: scene-table configuration write bus
// cfg_we   : write strobe, one entry per cycle
// cfg_addr : scene-table index
// cfg_data : {duration, audio_en, solid_color[5:0], background_state[7:0]}
interface scene_sequencer_if #(
    parameter int NUM_SCENES = 8,
    parameter int FRAME_W = 8
);
    localparam int IDX_W = $clog2(NUM_SCENES);
    logic cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [FRAME_W+14:0] cfg_data;
    modport master (output cfg_we, cfg_addr, cfg_data);
    modport slave (input cfg_we, cfg_addr, cfg_data);
endinterface

// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-synchronous scene scheduler for colour/audio configuration
// clk, rst_n          : pixel clock, synchronous active-low reset
// vsync               : vertical sync, polarity set by VSYNC_ACTIVE_LOW
// run, manual_mode    : autoplay enable, asynchronous pass-through select
// spi_*               : quasi-static manual configuration
// cfg                 : scene-table write bus
// background_state, solid_color, audio_en : registered configuration outputs
// scene_idx, mode, frame_tick             : current scene, 0 idle/1 play/2 manual, frame pulse
module scene_sequencer #(
    parameter int NUM_SCENES = 8,
    parameter int FRAME_W = 8,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    localparam int IDX_W = $clog2(NUM_SCENES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    input  logic run,
    input  logic manual_mode,
    input  logic [7:0] spi_background_state,
    input  logic [5:0] spi_solid_color,
    input  logic spi_audio_en,
    scene_sequencer_if.slave cfg,
    output logic [7:0] background_state,
    output logic [5:0] solid_color,
    output logic audio_en,
    output logic [IDX_W-1:0] scene_idx,
    output logic [1:0] mode,
    output logic frame_tick
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, MANUAL = 2'd2} state_t;
    localparam int EW = FRAME_W + 15;
    localparam logic [EW-1:0] ENTRY_RST = {FRAME_W'(1), 15'd0};
    state_t state, state_nxt;
    logic [EW-1:0] table_q [NUM_SCENES];
    logic act_q, act_d, man_m, man_s, load;
    logic [FRAME_W-1:0] cnt, cnt_nxt, dur;
    logic [IDX_W-1:0] idx_nxt, ld_idx;
    logic [14:0] out_nxt;
    logic [EW-1:0] ent;

    assign mode = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt = scene_idx;
        cnt_nxt = cnt;
        out_nxt = {audio_en, solid_color, background_state};
        load = 1'b0;
        ld_idx = scene_idx;
        if (frame_tick) begin
            if (man_s) begin
                state_nxt = MANUAL;
                out_nxt = {spi_audio_en, spi_solid_color, spi_background_state};
            end else if (state == PLAY) begin
                if (!run) state_nxt = IDLE;
                else if (cnt != '0) cnt_nxt = cnt - FRAME_W'(1);
                else begin
                    ld_idx = (scene_idx == IDX_W'(NUM_SCENES - 1)) ? '0 : scene_idx + IDX_W'(1);
                    load = 1'b1;
                end
            end else begin
                // IDLE and MANUAL-exit behave alike: start the current scene afresh or hold
                state_nxt = run ? PLAY : IDLE;
                load = run;
            end
        end
        // table read happens before this edge's write lands, so a colliding load sees old data
        ent = table_q[ld_idx];
        dur = ent[EW-1:15];
        if (load) begin
            idx_nxt = ld_idx;
            out_nxt = ent[14:0];
            cnt_nxt = (dur == '0) ? '0 : dur - FRAME_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q <= 1'b0;
            act_d <= 1'b0;
            frame_tick <= 1'b0;
            man_m <= 1'b0;
            man_s <= 1'b0;
            scene_idx <= '0;
            cnt <= '0;
            {audio_en, solid_color, background_state} <= '0;
            for (int i = 0; i < NUM_SCENES; i++) table_q[i] <= ENTRY_RST;
        end else begin
            // polarity is folded in at the input flop so the edge detector always sees active-high
            act_q <= vsync ^ VSYNC_ACTIVE_LOW;
            act_d <= act_q;
            frame_tick <= act_q & ~act_d;
            man_m <= manual_mode;
            man_s <= man_m;
            scene_idx <= idx_nxt;
            cnt <= cnt_nxt;
            {audio_en, solid_color, background_state} <= out_nxt;
            if (cfg.cfg_we) table_q[cfg.cfg_addr] <= cfg.cfg_data;
        end
    end
endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: randomized frame stimulus against a frame-level scene model, both vsync polarities
module tb_scene_sequencer;
    localparam int NS = 8, FW = 8, IW = 3, EW = FW + 15;
    logic clk = 1'b0, rst_n = 1'b0, act = 1'b0, run = 1'b0, manual_mode = 1'b0;
    logic [7:0] spi_bg = '0;
    logic [5:0] spi_col = '0;
    logic spi_aud = 1'b0;
    logic cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [EW-1:0] cfg_data = '0;
    logic [7:0] bg0, bg1;
    logic [5:0] col0, col1;
    logic aud0, aud1, tick0, tick1;
    logic [IW-1:0] idx0, idx1;
    logic [1:0] mode0, mode1;
    logic [20:0] got0, got1, exp_v;
    int tests = 0, fails = 0, ticks = 0;
    bit rnd = 1'b0;
    logic [EW-1:0] m_tab [NS];
    int m_mode, m_idx, m_shown, m_len;
    logic [14:0] m_out;
    logic m_tick;
    logic [1:0] a_h, man_h;

    always #5 clk = ~clk;

    scene_sequencer_if #(.NUM_SCENES(NS), .FRAME_W(FW)) cif0 ();
    scene_sequencer_if #(.NUM_SCENES(NS), .FRAME_W(FW)) cif1 ();
    assign cif0.cfg_we = cfg_we;
    assign cif0.cfg_addr = cfg_addr;
    assign cif0.cfg_data = cfg_data;
    assign cif1.cfg_we = cfg_we;
    assign cif1.cfg_addr = cfg_addr;
    assign cif1.cfg_data = cfg_data;

    scene_sequencer #(.NUM_SCENES(NS), .FRAME_W(FW), .VSYNC_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .vsync(~act), .run(run), .manual_mode(manual_mode),
        .spi_background_state(spi_bg), .spi_solid_color(spi_col), .spi_audio_en(spi_aud),
        .cfg(cif0), .background_state(bg0), .solid_color(col0), .audio_en(aud0),
        .scene_idx(idx0), .mode(mode0), .frame_tick(tick0)
    );
    scene_sequencer #(.NUM_SCENES(NS), .FRAME_W(FW), .VSYNC_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .vsync(act), .run(run), .manual_mode(manual_mode),
        .spi_background_state(spi_bg), .spi_solid_color(spi_col), .spi_audio_en(spi_aud),
        .cfg(cif1), .background_state(bg1), .solid_color(col1), .audio_en(aud1),
        .scene_idx(idx1), .mode(mode1), .frame_tick(tick1)
    );

    assign got0 = {bg0, col0, aud0, idx0, mode0, tick0};
    assign got1 = {bg1, col1, aud1, idx1, mode1, tick1};
    assign exp_v = {m_out[7:0], m_out[13:8], m_out[14], IW'(m_idx), 2'(m_mode), m_tick};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_scene();
        logic [EW-1:0] e;
        e = m_tab[m_idx];
        m_out = e[14:0];
        m_len = (e[EW-1:15] == '0) ? 1 : int'(e[EW-1:15]);
        m_shown = 1;
    endtask

    // Scene model: a scene shows for m_len frames, counted upward from its first frame.
    task automatic model_step();
        if (!rst_n) begin
            m_mode = 0; m_idx = 0; m_shown = 0; m_len = 0;
            m_out = '0; m_tick = 1'b0; a_h = '0; man_h = '0;
            for (int i = 0; i < NS; i++) m_tab[i] = {FW'(1), 15'd0};
        end else begin
            if (m_tick) begin
                if (man_h[1]) begin
                    m_mode = 2;
                    m_out = {spi_aud, spi_col, spi_bg};
                end else if (m_mode == 1 && !run) m_mode = 0;
                else if (m_mode == 1 && m_shown < m_len) m_shown++;
                else if (m_mode == 1) begin
                    m_idx = (m_idx + 1) % NS;
                    load_scene();
                end else if (run) begin
                    m_mode = 1;
                    load_scene();
                end else m_mode = 0;
            end
            if (cfg_we) m_tab[cfg_addr] = cfg_data;
            m_tick = a_h[0] & ~a_h[1];
            a_h = {a_h[0], act};
            man_h = {man_h[0], manual_mode};
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic step(input logic a);
        @(negedge clk);
        check("dut_lo", 32'(got0), 32'(exp_v));
        check("dut_hi", 32'(got1), 32'(exp_v));
        ticks += int'(tick0);
        act = a;
        cfg_we = 1'b0;
        if (rnd) begin
            if ($urandom_range(5) == 0) {spi_aud, spi_col, spi_bg} = 15'($urandom);
            if ($urandom_range(5) == 0) begin
                cfg_we = 1'b1;
                cfg_addr = IW'($urandom);
                cfg_data = {FW'($urandom_range(3)), 15'($urandom)};
            end
        end
    endtask

    task automatic frame(input int hold, input int gap);
        ticks = 0;
        repeat (hold) step(1'b1);
        repeat (gap) step(1'b0);
        check("ticks_per_frame", 32'(ticks), 32'd1);
    endtask

    task automatic wr(input int a, input logic [EW-1:0] d);
        step(1'b0);
        cfg_we = 1'b1;
        cfg_addr = IW'(a);
        cfg_data = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        act = 1'b0;
        cfg_we = 1'b0;
        @(negedge clk);
        check("reset_lo", 32'(got0), 32'd0);
        check("reset_hi", 32'(got1), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        wr(0, {FW'(2), 7'd0, 8'h01});
        wr(1, {FW'(0), 7'd0, 8'h02});
        run = 1'b1;
        repeat (9) frame(2, 6);
        check("wrap_idx7", 32'(idx0), 32'd7);
        frame(2, 6);
        check("wrap_idx0", 32'(idx0), 32'd0);
        check("wrap_bg", 32'(bg0), 32'h01);
        {spi_aud, spi_col, spi_bg} = {1'b1, 6'h2A, 8'hA5};
        manual_mode = 1'b1;
        frame(2, 6);
        check("manual_mode", 32'(mode0), 32'd2);
        check("manual_out", 32'({aud0, col0, bg0}), 32'({1'b1, 6'h2A, 8'hA5}));
        manual_mode = 1'b0;
        frame(3, 5);
        check("manual_exit_mode", 32'(mode0), 32'd1);
        check("manual_exit_bg", 32'(bg0), 32'h01);
        run = 1'b0;
        repeat (4) frame(1, 4);
        check("pause_mode", 32'(mode0), 32'd0);
        run = 1'b1;
        repeat (4) frame(2, 5);
        rnd = 1'b1;
        frame(2000, 5);
        repeat (300) begin
            if ($urandom_range(7) == 0) run = ~run;
            if ($urandom_range(9) == 0) manual_mode = ~manual_mode;
            frame($urandom_range(1, 6), $urandom_range(3, 20));
        end
        rnd = 1'b0;
        manual_mode = 1'b0;
        do_reset();
        run = 1'b1;
        frame(2, 6);
        check("post_reset_mode", 32'(mode0), 32'd1);
        check("post_reset_out", 32'({aud0, col0, bg0, idx0}), 32'd0);
        repeat (3) frame(2, 6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
